// File: rtl/tone_capture.sv
// tone_capture: segments a square-wave audio line into tone/rest events (period in cycles, duration in ms)
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   enable                capture enable; dropping it closes the open segment
//   audio_in              asynchronous square-wave input
//   clear_ovf             clears the sticky overflow flag
//   evt_valid, evt_ready  event FIFO head handshake
//   evt_rest              1 = rest event, 0 = tone event
//   evt_period            tone period in cycles (0 for rest)
//   evt_dur_ms            event duration in ms, saturating
//   overflow              sticky: an event was dropped on a full FIFO
module tone_capture #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int PERIOD_W    = 24,
    parameter int SILENCE_CYC = 200_000,
    parameter int TOL_CYC     = 2_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                audio_in,
    input  logic                clear_ovf,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_rest,
    output logic [PERIOD_W-1:0] evt_period,
    output logic [15:0]         evt_dur_ms,
    output logic                overflow
);
    localparam int DIV   = CLK_HZ / 1000;
    localparam int PRE_W = $clog2(DIV + 1);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {S_OFF, S_SYNC, S_LOCK, S_TONE, S_REST} state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync_q;
    logic [PRE_W-1:0]    pre_q;
    logic [31:0]         ms_q, seg_q, seg_d, last_q, last_d, span;
    logic [PERIOD_W-1:0] cnt_q, ref_q, ref_d, push_per;
    logic [PERIOD_W:0]   diff, adiff;
    logic [15:0]         dur;
    logic                tick, rise, timeout, off_tol;
    logic                push, push_rest, pop, full, wr_en, drop;
    logic [AW-1:0]       wr_q, rd_q;
    logic [AW:0]         fill_q;
    logic                rest_m [FIFO_DEPTH];
    logic [PERIOD_W-1:0] per_m  [FIFO_DEPTH];
    logic [15:0]         dur_m  [FIFO_DEPTH];

    // sync_q[1] is the synchronized line, sync_q[2] its previous value
    assign rise    = sync_q[1] & ~sync_q[2];
    assign tick    = pre_q == PRE_W'(DIV - 1);
    assign timeout = cnt_q == PERIOD_W'(SILENCE_CYC);
    assign diff    = {1'b0, cnt_q} - {1'b0, ref_q};
    assign adiff   = diff[PERIOD_W] ? -diff : diff;
    assign off_tol = adiff > (PERIOD_W + 1)'(TOL_CYC);
    assign dur     = |span[31:16] ? 16'hFFFF : span[15:0];

    // enable low is tested first in every active state so it dominates edges and timeouts
    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        last_d    = last_q;
        ref_d     = ref_q;
        push      = 1'b0;
        push_rest = 1'b0;
        push_per  = ref_q;
        span      = last_q - seg_q;
        case (state_q)
            S_OFF: state_d = enable ? S_SYNC : S_OFF;
            S_SYNC: begin
                if (!enable) begin
                    state_d = S_OFF;
                end else if (rise) begin
                    seg_d   = ms_q;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (!enable) begin
                    state_d = S_OFF;
                end else if (rise) begin
                    ref_d   = cnt_q;
                    last_d  = ms_q;
                    state_d = S_TONE;
                end else if (timeout) begin
                    state_d = S_REST;
                end
            end
            S_TONE: begin
                if (!enable) begin
                    push    = 1'b1;
                    state_d = S_OFF;
                end else if (rise) begin
                    push   = off_tol;
                    seg_d  = off_tol ? last_q : seg_q;
                    ref_d  = off_tol ? cnt_q : ref_q;
                    last_d = ms_q;
                end else if (timeout) begin
                    push    = 1'b1;
                    seg_d   = last_q;
                    state_d = S_REST;
                end
            end
            S_REST: begin
                push_rest = 1'b1;
                push_per  = '0;
                span      = ms_q - seg_q;
                if (!enable) begin
                    push    = 1'b1;
                    state_d = S_OFF;
                end else if (rise) begin
                    push    = 1'b1;
                    seg_d   = ms_q;
                    state_d = S_LOCK;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    assign pop   = evt_valid & evt_ready;
    assign full  = fill_q == (AW + 1)'(FIFO_DEPTH);
    assign wr_en = push & (dur != 16'd0) & (~full | pop);
    assign drop  = push & (dur != 16'd0) & full & ~pop;

    // the period counter loads 1 on an edge so that at the next edge it holds the edge spacing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            pre_q   <= '0;
            ms_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_OFF;
            seg_q   <= '0;
            last_q  <= '0;
            ref_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fill_q  <= '0;
            overflow <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], audio_in};
            pre_q   <= tick ? '0 : pre_q + 1'b1;
            ms_q    <= ms_q + {31'd0, tick};
            cnt_q   <= rise ? PERIOD_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
            state_q <= state_d;
            seg_q   <= seg_d;
            last_q  <= last_d;
            ref_q   <= ref_d;
            wr_q    <= wr_en ? wr_q + 1'b1 : wr_q;
            rd_q    <= pop ? rd_q + 1'b1 : rd_q;
            fill_q  <= fill_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
            overflow <= drop | (overflow & ~clear_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rest_m[wr_q] <= push_rest;
            per_m[wr_q]  <= push_per;
            dur_m[wr_q]  <= dur;
        end
    end

    // head fields are gated so every output reads zero while the FIFO is empty or in reset
    assign evt_valid  = fill_q != '0;
    assign evt_rest   = evt_valid & rest_m[rd_q];
    assign evt_period = evt_valid ? per_m[rd_q] : '0;
    assign evt_dur_ms = evt_valid ? dur_m[rd_q] : '0;
endmodule

// File: tb/tb_tone_capture.sv
// tb_tone_capture: randomized scenarios checked against a segmentation model of edge times
module tb_tone_capture;
    localparam int PW = 24, SIL = 4000, TOL = 20, DIV = 1000, DEPTH = 4;

    typedef struct {
        bit rest;
        int per;
        int dur;
    } evt_t;

    logic          clk = 1'b0, reset = 1'b1, enable = 1'b0, audio_in = 1'b0;
    logic          clear_ovf = 1'b0, evt_ready = 1'b1;
    logic          evt_valid, evt_rest, overflow;
    logic [PW-1:0] evt_period;
    logic [15:0]   evt_dur_ms;
    int            cyc = 0, checks = 0, errors = 0;
    int            eq[$];
    evt_t          exp_q[$], got_q[$];

    tone_capture #(
        .CLK_HZ(1_000_000), .PERIOD_W(PW), .SILENCE_CYC(SIL), .TOL_CYC(TOL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .audio_in(audio_in), .clear_ovf(clear_ovf),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_rest(evt_rest),
        .evt_period(evt_period), .evt_dur_ms(evt_dur_ms), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        evt_t e;
        if (!reset && evt_valid && evt_ready) begin
            e.rest = evt_rest;
            e.per  = int'(evt_period);
            e.dur  = int'(evt_dur_ms);
            got_q.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 evt_ready = v;
        @(negedge clk);
    endtask

    // n rising edges with the given spacing; each edge is logged at the cycle the decoder acts on it
    task automatic train(input int per, input int jit, input int n);
        for (int k = 0; k < n; k++) begin
            int p;
            p = per + ((jit > 0) ? int'($urandom_range(2 * jit)) - jit : 0);
            audio_in = 1'b1;
            eq.push_back(cyc + 3);
            wait_cyc(p / 2);
            audio_in = 1'b0;
            wait_cyc(p - p / 2);
        end
    endtask

    task automatic do_reset();
        #3 reset = 1'b1;
        enable    = 1'b0;
        audio_in  = 1'b0;
        clear_ovf = 1'b0;
        evt_ready = 1'b1;
        wait_cyc(3);
        #2 reset = 1'b0;
        wait_cyc(2);
        eq.delete();
        exp_q.delete();
        got_q.delete();
        enable = 1'b1;
    endtask

    function automatic void add(input bit rest, input int per, input int d);
        evt_t e;
        e.rest = rest;
        e.per  = per;
        e.dur  = d;
        exp_q.push_back(e);
    endfunction

    // Edges closer than SIL form a burst. A burst opens a segment at its first edge; its first
    // spacing is the reference pitch, and a spacing off by more than TOL closes the tone at the
    // previous edge. A burst ended by silence leaves a rest open from its last edge.
    function automatic void model(input int te, input bit dis);
        int  n, i, j, seg, rf, d;
        bit  rest_open;
        n = eq.size();
        i = 0;
        seg = 0;
        rest_open = 1'b0;
        exp_q.delete();
        while (i < n) begin
            j = i;
            while (j + 1 < n && eq[j+1] - eq[j] < SIL) j++;
            if (rest_open) add(1'b1, 0, eq[i] - seg);
            seg = eq[i];
            rest_open = (j + 1 < n) || (te - eq[j] > SIL);
            if (j > i) begin
                rf = eq[i+1] - eq[i];
                for (int k = i + 2; k <= j; k++) begin
                    d = eq[k] - eq[k-1] - rf;
                    if (d > TOL || d < -TOL) begin
                        add(1'b0, rf, eq[k-1] - seg);
                        seg = eq[k-1];
                        rf  = eq[k] - eq[k-1];
                    end
                end
                if (rest_open || dis) add(1'b0, rf, eq[j] - seg);
                seg = eq[j];
            end
            i = j + 1;
        end
        if (dis && rest_open) add(1'b1, 0, te - seg);
    endfunction

    task automatic compare(input string name);
        int lo, hi;
        check({name, " count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            lo = exp_q[k].dur / DIV;
            hi = (exp_q[k].dur + DIV - 1) / DIV;
            check($sformatf("%s[%0d] rest", name, k), got_q[k].rest, exp_q[k].rest);
            check($sformatf("%s[%0d] period", name, k), got_q[k].per, exp_q[k].per);
            check($sformatf("%s[%0d] dur_in_range dur=%0d want %0d..%0d", name, k, got_q[k].dur, lo, hi),
                  got_q[k].dur >= lo && got_q[k].dur <= hi, 1'b1);
        end
    endtask

    task automatic finish_scn(input string name, input bit dis);
        int te;
        te = dis ? cyc + 1 : cyc;
        if (dis) enable = 1'b0;
        wait_cyc(8);
        model(te, dis);
        compare(name);
    endtask

    initial begin
        int pa, pb;
        wait_cyc(2);
        check("rst valid", evt_valid, 1'b0);
        check("rst rest", evt_rest, 1'b0);
        check("rst period", evt_period, 0);
        check("rst dur", evt_dur_ms, 0);
        check("rst overflow", overflow, 1'b0);

        do_reset();
        train(1020 + int'($urandom_range(150)), 0, 5 + int'($urandom_range(3)));
        wait_cyc(3500);
        finish_scn("single", 1'b0);

        do_reset();
        pa = 1020 + int'($urandom_range(100));
        pb = pa + 60 + int'($urandom_range(60));
        train(pa, 0, 3);
        train(pb, 0, 3);
        wait_cyc(3500);
        finish_scn("pitch", 1'b0);

        do_reset();
        pa = 1020 + int'($urandom_range(150));
        train(pa, 0, 3);
        wait_cyc(3500 + int'($urandom_range(1000)));
        train(pa, 0, 3);
        wait_cyc(3500);
        finish_scn("rest", 1'b0);

        do_reset();
        train(1100 + int'($urandom_range(100)), 8, 6);
        wait_cyc(3500);
        finish_scn("jitter", 1'b0);

        do_reset();
        train(1100, 0, 1);
        wait_cyc(3500);
        finish_scn("lone", 1'b1);

        do_reset();
        train(1020 + int'($urandom_range(150)), 0, 5);
        finish_scn("disable", 1'b1);

        do_reset();
        set_ready(1'b0);
        for (int k = 0; k < 6; k++) train(1020 + 40 * k + int'($urandom_range(10)), 0, 2);
        wait_cyc(3500);
        model(cyc, 1'b0);
        check("bp overflow set", overflow, exp_q.size() > DEPTH);
        set_ready(1'b1);
        wait_cyc(8);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        compare("backpressure");
        check("bp overflow sticky", overflow, 1'b1);
        clear_ovf = 1'b1;
        wait_cyc(1);
        clear_ovf = 1'b0;
        wait_cyc(1);
        check("bp overflow cleared", overflow, 1'b0);

        do_reset();
        set_ready(1'b0);
        pa = 1020 + int'($urandom_range(100));
        train(pa, 0, 4);
        train(pa + 80, 0, 2);
        check("pre_reset valid", evt_valid, 1'b1);
        #3 reset = 1'b1;
        #1;
        check("async valid", evt_valid, 1'b0);
        check("async rest", evt_rest, 1'b0);
        check("async period", evt_period, 0);
        check("async dur", evt_dur_ms, 0);
        check("async overflow", overflow, 1'b0);
        wait_cyc(2);
        #2 reset = 1'b0;
        set_ready(1'b1);
        wait_cyc(4500);
        check("post_reset events", got_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
